// File: rtl/lcd_time_writer.sv
// lcd_time_writer
//   Feeds the i2c_lcd byte driver. After a power-up wait it brings an
//   HD44780-style LCD (4-bit mode behind a PCF8574 backpack) up with a fixed
//   command table. It then redraws "HH:MM:SS" at line 1, column 0 whenever an
//   update is requested.
//
//   Every byte uses the same handshake with the driver:
//     ISSUE : send_buffer/rs driven, send=1, held until lcd_busy is sampled high
//     WAIT  : send=0, held until lcd_busy is sampled low, then the next byte
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   update       one-cycle redraw request
//   hour10..sec1 BCD digits of the current time
//   lcd_busy     busy flag from i2c_lcd
//   send_buffer  byte presented to the driver
//   send         byte request to the driver
//   rs           0 = command byte, 1 = data byte
//   init_done    high once the init table has been sent (sticky until reset)
//   writing      high while a redraw is in progress
module lcd_time_writer #(
  parameter int POWERUP_CYCLES = 4_000_000,
  localparam int INIT_LEN = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       update,
  input  logic [3:0] hour10,
  input  logic [3:0] hour1,
  input  logic [3:0] min10,
  input  logic [3:0] min1,
  input  logic [3:0] sec10,
  input  logic [3:0] sec1,
  input  logic       lcd_busy,
  output logic [7:0] send_buffer,
  output logic       send,
  output logic       rs,
  output logic       init_done,
  output logic       writing
);

  // Top-level sequencer states
  localparam logic [2:0] ST_POWERUP = 3'd0;
  localparam logic [2:0] ST_INIT    = 3'd1;
  localparam logic [2:0] ST_IDLE    = 3'd2;
  localparam logic [2:0] ST_CURSOR  = 3'd3;
  localparam logic [2:0] ST_CHARS   = 3'd4;

  // Per-byte handshake phases
  localparam logic PH_ISSUE = 1'b0;
  localparam logic PH_WAIT  = 1'b1;

  localparam logic [7:0] CMD_CURSOR = 8'h80;  // DDRAM address 0x00: line 1, column 0
  localparam logic [7:0] CHAR_COLON = 8'h3A;
  localparam logic [7:0] CHAR_BAD   = 8'h3F;  // '?' for a non-BCD digit

  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);
  localparam logic [2:0] CHAR_LAST = 3'd7;

  localparam int CNT_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Init table: 0x33/0x32 force 4-bit mode, 0x28 two lines 5x8,
  // 0x0C display on cursor off, 0x01 clear, 0x06 increment no shift.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h33;
      3'd1:    init_cmd = 8'h32;
      3'd2:    init_cmd = 8'h28;
      3'd3:    init_cmd = 8'h0C;
      3'd4:    init_cmd = 8'h01;
      3'd5:    init_cmd = 8'h06;
      default: init_cmd = 8'h00;
    endcase
  endfunction

  // ASCII digit, or '?' when the nibble is not a BCD digit
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    if (d <= 4'd9) begin
      digit_char = 8'h30 + {4'h0, d};
    end else begin
      digit_char = CHAR_BAD;
    end
  endfunction

  // Character at position pos of "HH:MM:SS"
  function automatic logic [7:0] frame_char(
    input logic [2:0] pos,
    input logic [3:0] h10,
    input logic [3:0] h1,
    input logic [3:0] m10,
    input logic [3:0] m1,
    input logic [3:0] s10,
    input logic [3:0] s1
  );
    case (pos)
      3'd0:    frame_char = digit_char(h10);
      3'd1:    frame_char = digit_char(h1);
      3'd2:    frame_char = CHAR_COLON;
      3'd3:    frame_char = digit_char(m10);
      3'd4:    frame_char = digit_char(m1);
      3'd5:    frame_char = CHAR_COLON;
      3'd6:    frame_char = digit_char(s10);
      3'd7:    frame_char = digit_char(s1);
      default: frame_char = CHAR_BAD;
    endcase
  endfunction

  logic [2:0]       state_r;
  logic             phase_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic             pending_r;

  // Digits frozen at the start of a redraw; only these are transmitted
  logic [3:0] h10_r, h1_r, m10_r, m1_r, s10_r, s1_r;

  logic       start_s;
  logic       follow_s;
  logic [2:0] next_state_s;
  logic [2:0] next_idx_s;
  logic [7:0] next_byte_s;
  logic       next_rs_s;
  logic       fin_init_s;
  logic       fin_frame_s;

  assign start_s = (state_r == ST_IDLE) && (update || pending_r);

  // What happens once the current byte's busy pulse has ended:
  // either another byte follows (follow_s) or the sequence closes out.
  always_comb begin
    follow_s     = 1'b0;
    next_state_s = state_r;
    next_idx_s   = idx_r;
    next_byte_s  = send_buffer;
    next_rs_s    = rs;
    fin_init_s   = 1'b0;
    fin_frame_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (idx_r == INIT_LAST) begin
          next_state_s = ST_IDLE;
          fin_init_s   = 1'b1;
        end else begin
          follow_s    = 1'b1;
          next_idx_s  = idx_r + 3'd1;
          next_byte_s = init_cmd(idx_r + 3'd1);
          next_rs_s   = 1'b0;
        end
      end
      ST_CURSOR: begin
        follow_s     = 1'b1;
        next_state_s = ST_CHARS;
        next_idx_s   = 3'd0;
        next_byte_s  = frame_char(3'd0, h10_r, h1_r, m10_r, m1_r, s10_r, s1_r);
        next_rs_s    = 1'b1;
      end
      ST_CHARS: begin
        if (idx_r == CHAR_LAST) begin
          next_state_s = ST_IDLE;
          fin_frame_s  = 1'b1;
        end else begin
          follow_s    = 1'b1;
          next_idx_s  = idx_r + 3'd1;
          next_byte_s = frame_char(idx_r + 3'd1, h10_r, h1_r, m10_r, m1_r, s10_r, s1_r);
          next_rs_s   = 1'b1;
        end
      end
      default: begin
        follow_s = 1'b0;
      end
    endcase
  end

  // Main sequencer: power-up wait, init table, cursor command, frame characters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_POWERUP;
      phase_r     <= PH_ISSUE;
      cnt_r       <= '0;
      idx_r       <= 3'd0;
      send_buffer <= 8'h00;
      send        <= 1'b0;
      rs          <= 1'b0;
      init_done   <= 1'b0;
      writing     <= 1'b0;
      h10_r       <= 4'h0;
      h1_r        <= 4'h0;
      m10_r       <= 4'h0;
      m1_r        <= 4'h0;
      s10_r       <= 4'h0;
      s1_r        <= 4'h0;
    end else begin
      case (state_r)
        ST_POWERUP: begin
          if (cnt_r == CNT_MAX) begin
            cnt_r       <= '0;
            state_r     <= ST_INIT;
            idx_r       <= 3'd0;
            phase_r     <= PH_ISSUE;
            send_buffer <= init_cmd(3'd0);
            rs          <= 1'b0;
            send        <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (start_s) begin
            h10_r       <= hour10;
            h1_r        <= hour1;
            m10_r       <= min10;
            m1_r        <= min1;
            s10_r       <= sec10;
            s1_r        <= sec1;
            writing     <= 1'b1;
            state_r     <= ST_CURSOR;
            phase_r     <= PH_ISSUE;
            send_buffer <= CMD_CURSOR;
            rs          <= 1'b0;
            send        <= 1'b1;
          end
        end
        ST_INIT, ST_CURSOR, ST_CHARS: begin
          if (phase_r == PH_ISSUE) begin
            // Byte accepted once the driver raises busy; drop the request.
            if (lcd_busy) begin
              send    <= 1'b0;
              phase_r <= PH_WAIT;
            end
          end else if (!lcd_busy) begin
            // Busy has ended: next byte (if any) goes out on this edge,
            // so send never rises while busy is still high.
            state_r     <= next_state_s;
            idx_r       <= next_idx_s;
            phase_r     <= PH_ISSUE;
            send        <= follow_s;
            send_buffer <= next_byte_s;
            rs          <= next_rs_s;
            if (fin_init_s) begin
              init_done <= 1'b1;
            end
            if (fin_frame_s) begin
              writing <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= ST_POWERUP;
        end
      endcase
    end
  end

  // Requests arriving during a redraw (including its final cycle) collapse
  // into one pending bit, consumed when the sequencer is back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= 1'b0;
    end else if (start_s) begin
      pending_r <= 1'b0;
    end else if (update && writing) begin
      pending_r <= 1'b1;
    end
  end

endmodule

// File: doc/lcd_time_writer.md
Name: lcd_time_writer

Overview:
- Upstream feeder for the i2c_lcd byte driver.
- Brings the HD44780-style LCD (4-bit mode over the PCF8574 backpack) out of power-up with a fixed command sequence.
- On each update request, writes the current BCD time as "HH:MM:SS" to line 1, column 0.
- All traffic uses the driver's send_buffer/send/rs/busy handshake.

Parameters:
- POWERUP_CYCLES, 4_000_000, clk cycles to wait after reset before the first init command (40 ms at 100 MHz).
- INIT_LEN, 6, number of init commands issued. Fixed table, not user-sizable.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- update  input  1  one-cycle request to redraw time
- hour10  input  4  BCD tens of hours
- hour1  input  4  BCD units of hours
- min10  input  4  BCD tens of minutes
- min1  input  4  BCD units of minutes
- sec10  input  4  BCD tens of seconds
- sec1  input  4  BCD units of seconds
- lcd_busy  input  1  busy from i2c_lcd
- send_buffer  output  8  byte to driver
- send  output  1  byte request to driver
- rs  output  1  0 = command, 1 = data
- init_done  output  1  high once init sequence is complete
- writing  output  1  high while a redraw is in progress

Behaviour:
- Reset is synchronous: sampled only on posedge clk.
- Reset values: send_buffer=0, send=0, rs=0, init_done=0, writing=0. Counters are cleared, the pending flag is cleared and state goes to POWERUP.
- Reset mid-transfer drops send on the next edge and restarts from POWERUP. The downstream driver is not otherwise notified.
- Top states:
  - POWERUP: count to POWERUP_CYCLES-1, then go to INIT.
  - INIT: issue commands 0x33, 0x32, 0x28, 0x0C, 0x01, 0x06 in order with rs=0. After the last byte completes, set init_done=1 (sticky until reset) and go to IDLE.
  - IDLE: on update (or pending set), snapshot all six digit inputs into internal registers, clear pending, set writing=1 and go to CURSOR.
  - CURSOR: issue 0x80 with rs=0, then go to CHARS.
  - CHARS: issue 8 data bytes with rs=1 in order: H10, H1, ':', M10, M1, ':', S10, S1. After the 8th byte completes, clear writing and return to IDLE.
- Byte sub-sequence, used for every byte:
  - ISSUE: drive send_buffer/rs, send=1. Hold until lcd_busy==1 is sampled.
  - WAIT: send=0 on the edge after busy is seen. Wait until lcd_busy==0, then advance to the next byte on the following cycle.
  - send_buffer and rs stay stable from send rise until busy is seen.
  - send is never high for a new byte while lcd_busy is high.
- Character encoding:
  - A digit d in 0..9 is sent as 0x30+d.
  - A digit value 10..15 is sent as 0x3F ('?').
  - ':' is sent as 0x3A.
- Timing of update inputs:
  - update while init_done=0 is ignored. Not queued.
  - update while writing=1 sets pending (a single bit; multiple requests coalesce). One extra redraw starts from IDLE the cycle after the current redraw finishes, using digits snapshotted at that point.
  - update in the same cycle a redraw finishes is treated as pending.
- Digit inputs may change at any time. Only snapshot values are transmitted.

Test Plan:
- Power-up init: POWERUP_CYCLES=100, lcd_busy model responds 2 cycles after send and holds 20 cycles.
  - No send before cycle 100.
  - Then exactly 0x33, 0x32, 0x28, 0x0C, 0x01, 0x06 with rs=0.
  - init_done rises after the 6th busy falls.
- Redraw 12:34:56: after init, pulse update with digits 1, 2, 3, 4, 5, 6.
  - Bytes are 0x80 (rs=0), then 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 (rs=1).
  - writing is high from the cycle after update until the last busy falls.
- Snapshot/pending: during the 3rd character, change digits to 23:59:59 and pulse update twice.
  - The current frame still sends 12:34:56.
  - Exactly one further frame follows: 0x80, 0x32 0x33 0x3A 0x35 0x39 0x3A 0x35 0x39.
- Invalid BCD and early update:
  - update before init_done produces no bytes.
  - hour10=4'hA produces 0x3F in its slot.
- Handshake rules:
  - Busy model delays busy by 7 cycles: send stays high with stable send_buffer/rs throughout.
  - send falls exactly 1 cycle after busy is sampled high.
  - Assertion: send is never high while busy is high and the WAIT phase is active.
- Reset mid-redraw: assert reset at the 5th character.
  - Next edge: send=0, writing=0, init_done=0.
  - After release, the full power-up wait and init sequence repeat.
